// File: rtl/avalon_st_rr_arbiter.sv
// Packet-aware round-robin arbiter feeding the internal-clock side of avalon_dc_fifo.
// One requester owns the output per grant; data path is a zero-latency combinational mux.
module avalon_st_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk_int_clk,
  input  logic                      reset_int_reset,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         fifo_in_data,
  output logic                      fifo_in_valid,
  input  logic                      fifo_in_ready,
  output logic [NUM_REQ-1:0]        grant_onehot,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [IDX_W:0]   NUM_REQ_V = (IDX_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   gidx_reg, gidx_next;
  logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;

  logic [DATA_W-1:0]  req_data_arr [NUM_REQ];
  logic [NUM_REQ-1:0] grant_dec;
  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0] valid_rot;
  logic [IDX_W-1:0]   pick_off;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W:0]     pick_sum;
  logic [IDX_W:0]     gidx_inc;
  logic               pick_valid;
  logic               active;
  logic               g_valid;
  logic               g_last;
  logic               accept;
  logic               release_grant;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign req_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
      assign grant_dec[gi]    = (gidx_reg == IDX_W'(gi));
    end
  endgenerate

  // Rotate valids so that bit 0 is the pointer position, then take the lowest set bit.
  assign valid_dbl = {req_valid, req_valid};
  assign valid_rot = NUM_REQ'(valid_dbl >> ptr_reg);

  always_comb begin
    pick_valid = 1'b0;
    pick_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        pick_valid = 1'b1;
        pick_off   = IDX_W'(k);
      end
    end
  end

  assign pick_sum = {1'b0, ptr_reg} + {1'b0, pick_off};
  assign pick_idx = (pick_sum >= NUM_REQ_V) ? IDX_W'(pick_sum - NUM_REQ_V) : IDX_W'(pick_sum);
  assign gidx_inc = {1'b0, gidx_reg} + {{IDX_W{1'b0}}, 1'b1};

  // Reset gates every output so no beat can move while reset is asserted.
  assign active        = (state_reg == GRANT) && !reset_int_reset;
  assign g_valid       = req_valid[gidx_reg];
  assign g_last        = req_last[gidx_reg];
  assign accept        = active && g_valid && fifo_in_ready;
  assign release_grant = accept && (g_last || (beat_cnt_reg == CNT_LAST));

  assign fifo_in_data  = active ? req_data_arr[gidx_reg] : '0;
  assign fifo_in_valid = active && g_valid;
  assign grant_onehot  = active ? grant_dec : '0;
  assign req_ready     = (active && fifo_in_ready) ? grant_dec : '0;
  assign busy          = active;

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    gidx_next     = gidx_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          gidx_next     = pick_idx;
          beat_cnt_next = '0;
          state_next    = GRANT;
        end
      end
      GRANT: begin
        if (release_grant) begin
          ptr_next      = (gidx_inc == NUM_REQ_V) ? '0 : IDX_W'(gidx_inc);
          gidx_next     = '0;
          beat_cnt_next = '0;
          state_next    = IDLE;
        end else if (accept) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_int_clk) begin
    if (reset_int_reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      gidx_reg     <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      gidx_reg     <= gidx_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

endmodule

// File: tb/tb_avalon_st_rr_arbiter.sv
// Scoreboard bench for avalon_st_rr_arbiter: per-requester source queues drive beats,
// predicted output beats are queued up front and compared as the FIFO side accepts them.
module tb_avalon_st_rr_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int MB = 16;

  typedef struct { logic [63:0] data; logic last; } beat_t;
  typedef struct { logic [63:0] data; logic [NR-1:0] gnt; } exp_t;

  logic            clk;
  logic            srst;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [DW-1:0]   fifo_in_data;
  logic            fifo_in_valid;
  logic            fifo_in_ready;
  logic [NR-1:0]   grant_onehot;
  logic            busy;

  beat_t       src_q [NR][$];
  exp_t        exp_q [$];
  logic [NR-1:0] en;
  logic        rdy;
  logic [31:0] vhist;
  int          n_cmp;
  int          n_err;

  avalon_st_rr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk_int_clk    (clk),
    .reset_int_reset(srst),
    .req_data       (req_data),
    .req_valid      (req_valid),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .fifo_in_data   (fifo_in_data),
    .fifo_in_valid  (fifo_in_valid),
    .fifo_in_ready  (fifo_in_ready),
    .grant_onehot   (grant_onehot),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mkdata(input int r, input int s);
    return {8'(r), 24'hC0FFEE, 32'(s)};
  endfunction

  task automatic push_beat(input int r, input int s, input logic last, input logic to_exp);
    beat_t b;
    exp_t  e;
    b.data = mkdata(r, s);
    b.last = last;
    src_q[r].push_back(b);
    if (to_exp) begin
      e.data = b.data;
      e.gnt  = NR'(1 << r);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_exp(input int r, input int s);
    exp_t e;
    e.data = mkdata(r, s);
    e.gnt  = NR'(1 << r);
    exp_q.push_back(e);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      if (en[i] && src_q[i].size() > 0) begin
        req_valid[i]            = 1'b1;
        req_last[i]             = src_q[i][0].last;
        req_data[i*DW +: DW]    = src_q[i][0].data;
      end else begin
        req_valid[i]            = 1'b0;
        req_last[i]             = 1'b0;
        req_data[i*DW +: DW]    = '0;
      end
    end
    fifo_in_ready = rdy;
  endtask

  // One clock: sample handshakes at negedge, retire accepted source beats after the edge.
  task automatic cycle();
    logic [NR-1:0] acc;
    exp_t e;
    @(negedge clk);
    vhist = {vhist[30:0], fifo_in_valid};
    acc   = req_valid & req_ready;
    if (fifo_in_valid && fifo_in_ready) begin
      $display("beat grant=%b data=%h", grant_onehot, fifo_in_data);
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'(fifo_in_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", fifo_in_data, e.data);
        check("beat_grant", 64'(grant_onehot), 64'(e.gnt));
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (acc[i] && src_q[i].size() > 0) src_q[i].delete(0);
    drive_inputs();
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 64'(fifo_in_valid), 64'd0);
    check({tag, "_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_grant"}, 64'(grant_onehot), 64'd0);
    check({tag, "_busy"},  64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < NR; i++) src_q[i].delete();
    exp_q.delete();
    srst = 1'b1;
    drive_inputs();
    cycle();
    cycle();
    check_idle_outputs("in_reset");
    srst = 1'b0;
    #1;
    check_idle_outputs("after_reset");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    en    = '1;
    rdy   = 1'b1;
    vhist = '0;
    srst  = 1'b1;
    req_data  = '0;
    req_valid = '0;
    req_last  = '0;
    fifo_in_ready = 1'b1;
    do_reset();

    // Single requester, 3-beat packet
    push_beat(0, 0, 1'b0, 1'b1);
    push_beat(0, 1, 1'b0, 1'b1);
    push_beat(0, 2, 1'b1, 1'b1);
    drive_inputs();
    #1;
    check("t1_idle_grant", 64'(grant_onehot), 64'd0);
    check("t1_idle_valid", 64'(fifo_in_valid), 64'd0);
    cycle();
    check("t1_grant", 64'(grant_onehot), 64'b0001);
    check("t1_busy", 64'(busy), 64'd1);
    drain(20);
    check("t1_busy_after", 64'(busy), 64'd0);
    check("t1_grant_after", 64'(grant_onehot), 64'd0);

    // Pointer now at 1: req1 beats req0
    push_beat(0, 10, 1'b1, 1'b0);
    push_beat(1, 10, 1'b1, 1'b0);
    push_exp(1, 10);
    push_exp(0, 10);
    drive_inputs();
    drain(20);

    // All four valid, single-beat packets; bubble between grants
    do_reset();
    push_beat(0, 0, 1'b1, 1'b0);
    push_beat(0, 1, 1'b1, 1'b0);
    push_beat(1, 0, 1'b1, 1'b0);
    push_beat(2, 0, 1'b1, 1'b0);
    push_beat(3, 0, 1'b1, 1'b0);
    push_exp(0, 0);
    push_exp(1, 0);
    push_exp(2, 0);
    push_exp(3, 0);
    push_exp(0, 1);
    vhist = '0;
    drive_inputs();
    drain(40);
    check("t2_valid_pattern", 64'(vhist[9:0]), 64'(10'b0101010101));

    // MAX_BURST cut-off on a packet that never ends early
    for (int s = 0; s < 20; s++) push_beat(2, s, (s == 19), 1'b0);
    push_beat(3, 0, 1'b1, 1'b0);
    for (int s = 0; s < MB; s++) push_exp(2, s);
    push_exp(3, 0);
    for (int s = MB; s < 20; s++) push_exp(2, s);
    en[3] = 1'b0;
    drive_inputs();
    repeat (5) cycle();
    en[3] = 1'b1;
    drive_inputs();
    drain(100);

    // Back-pressure mid-burst
    for (int s = 0; s < 5; s++) push_beat(0, s, (s == 4), 1'b1);
    drive_inputs();
    repeat (3) cycle();
    rdy = 1'b0;
    drive_inputs();
    #1;
    for (int c = 0; c < 5; c++) begin
      check("t4_stall_valid", 64'(fifo_in_valid), 64'd1);
      check("t4_stall_data", fifo_in_data, mkdata(0, 2));
      check("t4_stall_ready", 64'(req_ready), 64'd0);
      check("t4_stall_grant", 64'(grant_onehot), 64'b0001);
      cycle();
    end
    rdy = 1'b1;
    drive_inputs();
    drain(20);

    // Reset during beat 2 of a req1 burst
    do_reset();
    for (int s = 0; s < 4; s++) push_beat(1, s, 1'b0, (s == 0));
    drive_inputs();
    drain(10);
    srst = 1'b1;
    #1;
    check_idle_outputs("t5_reset_high");
    cycle();
    check_idle_outputs("t5_reset_next");
    srst = 1'b0;
    src_q[1].delete();
    push_beat(0, 20, 1'b1, 1'b1);
    push_beat(1, 20, 1'b1, 1'b1);
    drive_inputs();
    #1;
    check("t5_post_grant", 64'(grant_onehot), 64'd0);
    drain(20);

    // Granted requester goes quiet; grant is held
    do_reset();
    push_beat(0, 0, 1'b0, 1'b1);
    push_beat(1, 0, 1'b1, 1'b0);
    drive_inputs();
    drain(10);
    for (int c = 0; c < 10; c++) begin
      check("t6_ready1", 64'(req_ready[1]), 64'd0);
      check("t6_grant", 64'(grant_onehot), 64'b0001);
      cycle();
    end
    push_beat(0, 1, 1'b1, 1'b1);
    push_exp(1, 0);
    drive_inputs();
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
